// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_boot_checker_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      WAIT_ID,
      RD_TS,
      WAIT_TS,
      CHECK,
      DONE
   } state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/sysid_timeout_counter.sv
// Per-transaction watchdog: counts cycles spent on one read and flags the
// last allowed cycle so the FSM can abort.
module sysid_timeout_counter
   import sysid_boot_checker_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic terminal
);

   localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] count;

   // Clear on entry to a read, then count up and hold at the terminal value.
   always_ff @(posedge clock) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && (count != LAST)) begin
         count <= count + TIMEOUT_W'(1);
      end
   end

   assign terminal = (count == LAST);

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads the system-ID slave (ID word, then timestamp),
// compares both against build-time values and reports done/ok/timeout.
module sysid_boot_checker
   import sysid_boot_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1671071542,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter int          MAX_RETRIES        = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   input  logic        m_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   // Retry counter only needs to reach MAX_RETRIES; keep at least one bit.
   localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   state_t        state;
   logic [RW-1:0] retries;
   logic          in_txn;
   logic          capture;
   logic          abort;
   logic          cnt_clr;
   logic          tc;
   logic          retry_ok;

   // Transaction status decoded from the current state and bus inputs.
   always_comb begin
      in_txn   = (state == RD_ID) || (state == WAIT_ID) ||
                 (state == RD_TS) || (state == WAIT_TS);
      capture  = ((state == WAIT_ID) || (state == WAIT_TS)) && m_readdatavalid;
      abort    = in_txn && tc && !capture;
      // Counter restarts whenever a new read begins: from idle, after a
      // capture, or after an abort that retries.
      cnt_clr  = !in_txn || capture || abort;
      retry_ok = (retries < RW'(MAX_RETRIES));
   end

   sysid_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .clock    (clock),
      .reset    (reset),
      .clr      (cnt_clr),
      .en       (in_txn),
      .terminal (tc)
   );

   // Sequencer with registered bus strobes, status flags and capture registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         retries   <= '0;
         m_address <= SYSID_ADDR_ID;
         m_read    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         id_ok     <= 1'b0;
         ts_ok     <= 1'b0;
         timeout   <= 1'b0;
         id_value  <= '0;
         ts_value  <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            if (retry_ok) begin
               // Restart the whole sequence from the ID word.
               retries   <= retries + RW'(1);
               m_read    <= 1'b1;
               m_address <= SYSID_ADDR_ID;
               state     <= RD_ID;
            end else begin
               m_read  <= 1'b0;
               timeout <= 1'b1;
               done    <= 1'b1;
               state   <= DONE;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     retries   <= '0;
                     id_ok     <= 1'b0;
                     ts_ok     <= 1'b0;
                     timeout   <= 1'b0;
                     busy      <= 1'b1;
                     m_read    <= 1'b1;
                     m_address <= SYSID_ADDR_ID;
                     state     <= RD_ID;
                  end
               end
               RD_ID: begin
                  if (!m_waitrequest) begin
                     m_read <= 1'b0;
                     state  <= WAIT_ID;
                  end
               end
               WAIT_ID: begin
                  if (capture) begin
                     id_value  <= m_readdata;
                     m_read    <= 1'b1;
                     m_address <= SYSID_ADDR_TS;
                     state     <= RD_TS;
                  end
               end
               RD_TS: begin
                  if (!m_waitrequest) begin
                     m_read <= 1'b0;
                     state  <= WAIT_TS;
                  end
               end
               WAIT_TS: begin
                  if (capture) begin
                     ts_value <= m_readdata;
                     state    <= CHECK;
                  end
               end
               CHECK: begin
                  id_ok <= (id_value == EXPECTED_ID);
                  ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
                  done  <= 1'b1;
                  state <= DONE;
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: behavioural Avalon slave, end-of-sequence
// model computed from latency arithmetic, per-cycle compare process.
module tb_sysid_boot_checker;

   localparam int          TO     = 8;
   localparam int          MAXR   = 2;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1671071542;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        m_address, m_read, m_waitrequest, m_readdatavalid;
   logic [31:0] m_readdata;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   always #5 clock = ~clock;

   sysid_boot_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .TIMEOUT_CYCLES     (TO),
      .MAX_RETRIES        (MAXR)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .busy            (busy),
      .done            (done),
      .id_ok           (id_ok),
      .ts_ok           (ts_ok),
      .timeout         (timeout),
      .id_value        (id_value),
      .ts_value        (ts_value)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // slave configuration
   int          stall_n   = 0;
   int          lat       = 1;
   logic        respond   = 1'b1;
   logic [31:0] words [0:1];
   logic        spur      = 1'b0;
   logic [31:0] spur_data = 32'h0;

   // slave state
   int          stall_cnt  = 0;
   logic        pend       = 1'b0;
   int          resp_cyc   = 0;
   logic [31:0] resp_data  = 32'h0;
   logic        prev_stall = 1'b0;
   logic        prev_addr  = 1'b0;

   // model
   logic        started = 1'b0;
   int          k       = 0;
   int          exp_done = 0;
   logic        e_id_ok = 1'b0, e_ts_ok = 1'b0, e_to = 1'b0;
   logic [31:0] e_id = 32'h0, e_ts = 32'h0;
   int          done_cnt = 0;
   bit          in_run, exp_d, exp_b;

   assign m_waitrequest   = m_read && (stall_cnt < stall_n);
   assign m_readdatavalid = (pend && respond && (cyc == resp_cyc)) || spur;
   assign m_readdata      = spur ? spur_data : resp_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
      end
   endtask

   // Avalon slave: stalls stall_n cycles per read, responds lat cycles after acceptance.
   always @(posedge clock) begin
      cyc        <= cyc + 1;
      prev_stall <= m_read && m_waitrequest;
      prev_addr  <= m_address;
      if (reset) begin
         stall_cnt <= 0;
         pend      <= 1'b0;
      end else begin
         if (pend && (cyc == resp_cyc)) pend <= 1'b0;
         if (m_read && m_waitrequest) begin
            stall_cnt <= stall_cnt + 1;
         end else if (m_read) begin
            stall_cnt <= 0;
            pend      <= 1'b1;
            resp_cyc  <= cyc + lat;
            resp_data <= words[m_address];
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clock) begin
      if (!reset) begin
         in_run = started && (cyc >= k) && (cyc < exp_done);
         exp_d  = started && (cyc == exp_done);
         exp_b  = started && (cyc > k) && (cyc <= exp_done);
         if (done === 1'b1) done_cnt++;
         chkb("done", done, exp_d);
         chkb("busy", busy, exp_b);
         if (!in_run) begin
            chkb("id_ok", id_ok, e_id_ok);
            chkb("ts_ok", ts_ok, e_ts_ok);
            chkb("timeout", timeout, e_to);
            chk("id_value", id_value, e_id);
            chk("ts_value", ts_value, e_ts);
         end else if (cyc > k) begin
            chkb("id_ok_clr", id_ok, 1'b0);
            chkb("ts_ok_clr", ts_ok, 1'b0);
            chkb("timeout_clr", timeout, 1'b0);
         end
         if (prev_stall) begin
            chkb("stall_read", m_read, 1'b1);
            chkb("stall_addr", m_address, prev_addr);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Raise start; the model accepts it only when no sequence is in flight.
   task automatic drive_start();
      start = 1'b1;
      if (!(started && (cyc <= exp_done))) begin
         started = 1'b1;
         k       = cyc;
         if (respond) begin
            exp_done = k + 6 + 2 * stall_n + 2 * (lat - 1);
            e_id_ok  = (words[0] == EXP_ID);
            e_ts_ok  = (words[1] == EXP_TS);
            e_to     = 1'b0;
            e_id     = words[0];
            e_ts     = words[1];
         end else begin
            exp_done = k + (MAXR + 1) * TO + 1;
            e_id_ok  = 1'b0;
            e_ts_ok  = 1'b0;
            e_to     = 1'b1;
         end
      end
   endtask

   task automatic pulse_start();
      drive_start();
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output int dc, input int budget);
      dc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            dc = cyc;
            break;
         end
      end
      if (dc < 0) begin
         checks++;
         errors++;
         $display("FAIL done_wait cyc=%0d got=no_done want=done_within_%0d", cyc, budget);
      end
   endtask

   initial begin
      int dc;
      int dc0;
      words[0] = 32'h0;
      words[1] = EXP_TS;
      repeat (3) step();
      reset = 1'b0;
      chkb("rst_m_read", m_read, 1'b0);
      chkb("rst_done", done, 1'b0);
      chk("rst_id_value", id_value, 32'h0);
      step();

      // 1: zero-wait, matching words
      pulse_start();
      wait_done(dc, 40);
      chk("t1_latency", dc - k, 6);
      chk("t1_ts_value", ts_value, 32'h639A8736);
      chkb("t1_id_ok", id_ok, 1'b1);
      chkb("t1_ts_ok", ts_ok, 1'b1);
      chkb("t1_timeout", timeout, 1'b0);
      repeat (3) step();

      // 2: wrong ID, flags held afterwards
      words[0] = 32'h1;
      step();
      pulse_start();
      wait_done(dc, 40);
      chkb("t2_id_ok", id_ok, 1'b0);
      chkb("t2_ts_ok", ts_ok, 1'b1);
      chk("t2_id_value", id_value, 32'h1);
      repeat (5) step();
      chkb("t2_ts_ok_held", ts_ok, 1'b1);

      // 3: three waitrequest cycles per read
      words[0] = 32'h0;
      stall_n  = 3;
      step();
      pulse_start();
      wait_done(dc, 60);
      chk("t3_latency", dc - k, 12);
      chkb("t3_id_ok", id_ok, 1'b1);
      chk("t3_ts_value", ts_value, EXP_TS);
      stall_n = 0;
      step();

      // 4: no response ever, spurious readdatavalid in RD_ID
      respond = 1'b0;
      step();
      pulse_start();
      spur      = 1'b1;
      spur_data = 32'hDEADBEEF;
      step();
      spur = 1'b0;
      wait_done(dc, 80);
      chk("t4_latency", dc - k, 25);
      chkb("t4_timeout", timeout, 1'b1);
      chkb("t4_id_ok", id_ok, 1'b0);
      chk("t4_id_value", id_value, 32'h0);
      respond = 1'b1;
      step();

      // 5: reset during WAIT_TS
      step();
      pulse_start();
      repeat (3) step();
      reset = 1'b1;
      step();
      reset   = 1'b0;
      started = 1'b0;
      e_id_ok = 1'b0;
      e_ts_ok = 1'b0;
      e_to    = 1'b0;
      e_id    = 32'h0;
      e_ts    = 32'h0;
      chkb("t5_m_read", m_read, 1'b0);
      chkb("t5_busy", busy, 1'b0);
      chkb("t5_done", done, 1'b0);
      chk("t5_ts_value", ts_value, 32'h0);
      chk("t5_id_value", id_value, 32'h0);
      repeat (2) step();
      pulse_start();
      wait_done(dc, 40);
      chk("t5_restart_latency", dc - k, 6);
      chkb("t5_restart_ts_ok", ts_ok, 1'b1);
      step();

      // 6: start while busy and in DONE ignored; restart in next IDLE
      step();
      dc0 = done_cnt;
      pulse_start();
      repeat (2) step();
      pulse_start();
      wait_done(dc, 40);
      chk("t6_latency", dc - k, 6);
      drive_start();
      step();
      chk("t6_done_pulses", done_cnt - dc0, 1);
      drive_start();
      step();
      start = 1'b0;
      wait_done(dc, 40);
      chk("t6_restart_latency", dc - k, 6);
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Avalon-MM master controller that sequences the two-word system-ID slave: on a start pulse it reads the ID word (address 0), then the timestamp word (address 1), and compares each against build-time expected values. It sits between the boot/reset-release logic and the system-ID slave. Software and the boot sequencer use its done/ok/timeout flags to gate release of the processor when the loaded image does not match the hardware build.

## Interface
Parameters:
- EXPECTED_ID, default 32'd0: value required at address 0.
- EXPECTED_TIMESTAMP, default 32'd1671071542: value required at address 1.
- TIMEOUT_CYCLES, default 255: max cycles per read transaction, from read assert to readdatavalid; range 2..65535.
- MAX_RETRIES, default 3: full-sequence retries after a timeout; 0 allowed.

Ports:
- clock  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; ignored while busy.
- m_address  out  1  0 = ID word, 1 = timestamp word.
- m_read  out  1  Avalon read strobe.
- m_waitrequest  in  1  slave stall; read held while high.
- m_readdata  in  32  read data, valid with readdatavalid.
- m_readdatavalid  in  1  response strobe, ≥1 cycle after acceptance.
- busy  out  1  high from cycle after start until done cycle inclusive.
- done  out  1  one-cycle pulse at end of sequence, pass or fail.
- id_ok  out  1  captured ID == EXPECTED_ID; held until next start.
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP; held.
- timeout  out  1  sequence ended by retry exhaustion; held.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

## Operation
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, DONE.
- IDLE: start=1 → RD_ID; clear id_ok, ts_ok, timeout, retry count.
- RD_x: m_read=1, m_address per state. Stay while m_waitrequest=1; else → WAIT_x.
- WAIT_x: m_read=0. m_readdatavalid=1 → capture m_readdata into id_value/ts_value, then → RD_TS or CHECK.
- readdatavalid outside WAIT_x is ignored; a stale response is never captured.
- Timeout counter: cleared on entry to RD_x, increments each cycle in RD_x/WAIT_x. At count == TIMEOUT_CYCLES-1 without capture, abort the read and drop m_read.
  - retries < MAX_RETRIES → retries+1, → RD_ID (full sequence restarts).
  - otherwise timeout=1, → DONE; id_ok/ts_ok stay 0.
- CHECK: register id_ok, ts_ok from 32-bit equality → DONE.
- DONE: done=1 for one cycle → IDLE.
- Retry counter width is clog2(MAX_RETRIES+1), minimum 1; no wrap.
- Reset: all outputs 0, state IDLE, counters 0. Mid-transaction reset drops m_read on the next edge; no completion is reported.

## Timing
- All outputs are registered.
- Zero-wait slave with readdatavalid one cycle after acceptance; start sampled in cycle k:
  - RD_ID in k+1.
  - WAIT_ID/capture in k+2.
  - RD_TS in k+3.
  - WAIT_TS/capture in k+4.
  - CHECK in k+5.
  - done and final flags visible in k+6.
- Each waitrequest cycle and each extra response-latency cycle adds one cycle.
- start in the DONE cycle is ignored; the earliest restart is start sampled in the following IDLE cycle.

## Structure
- Package sysid_boot_checker_pkg holds:
  - state enum;
  - SYSID_ADDR_ID = 1'b0, SYSID_ADDR_TS = 1'b1;
  - TIMEOUT_W = 16.
- Sub-module sysid_timeout_counter holds the clear/enable/terminal-count logic, parameterized by TIMEOUT_CYCLES. The FSM, capture registers and compare stay in the top.

## Test plan
- Zero-wait slave returns 0 then 1671071542 → done at k+6, id_ok=1, ts_ok=1, timeout=0, ts_value=32'h639A8736.
- Slave returns ID 32'h00000001 → done, id_ok=0, ts_ok=1; flags held until next start.
- waitrequest high 3 cycles on each read → done at k+12, correct capture, m_read held steady while stalled.
- Slave never asserts readdatavalid, TIMEOUT_CYCLES=8, MAX_RETRIES=2 → 3 sequence attempts, timeout=1, id_ok=ts_ok=0. Spurious readdatavalid in RD_ID is ignored.
- Reset asserted in WAIT_TS → next cycle all outputs 0, IDLE, no done. New start completes normally.
- start pulsed while busy → ignored; exactly one done pulse.
